// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned MEM_ADDR_W  = 5;
    localparam int unsigned MEM_DATA_W  = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter; slave = arbiter view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;

    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output done, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
    );

    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  done, rdata, busy, mem_read, mem_write, mem_addr, mem_data_in
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first active request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    localparam int unsigned CW = IDX_W + 1;

    logic [CW-1:0] cand;

    // ptr < NUM_REQ and off < NUM_REQ, so a single conditional subtract wraps cand
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + CW'(off);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!valid_c && req[cand[IDX_W-1:0]]) begin
                valid_c                   = 1'b1;
                idx_c                     = cand[IDX_W-1:0];
                grant_c[cand[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous memory between NUM_REQ requesters using a
// fixed four-cycle IDLE/ACCESS/CAPTURE/RESP sequence with round-robin grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0]  win_oh_q, win_oh_d;
    logic                op_q, op_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant_c;
    logic [IDX_W-1:0]    arb_idx_c;
    logic                arb_valid_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (ptr_q),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    // Pick the winner's op, address and write data out of the packed buses
    always_comb begin
        sel_we_c    = OP_READ;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_c == IDX_W'(i)) begin
                sel_we_c    = bus.we[i];
                sel_addr_c  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata_c = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_idx_d     = win_idx_q;
        win_oh_d      = win_oh_q;
        op_d          = op_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        rdata_d       = rdata_q;
        done_d        = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    win_idx_d     = arb_idx_c;
                    win_oh_d      = arb_grant_c;
                    op_d          = sel_we_c;
                    mem_write_d   = (sel_we_c == OP_WRITE);
                    mem_read_d    = (sel_we_c == OP_READ);
                    mem_addr_d    = sel_addr_c;
                    mem_data_in_d = sel_wdata_c;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (op_q == OP_READ) begin
                    rdata_d = bus.mem_data_out;
                end
                done_d  = win_oh_q;
                ptr_d   = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_idx_q     <= '0;
            win_oh_q      <= '0;
            op_q          <= OP_READ;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rdata_q       <= '0;
            done_q        <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_idx_q     <= win_idx_d;
            win_oh_q      <= win_oh_d;
            op_q          <= op_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a 32x8 memory model and a
// scoreboard of memory contents plus a round-robin grant model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rr_ptr = 0;
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] mem     [0:31];

    mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory with registered read data
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
        if (bus.mem_read)  bus.mem_data_out <= mem[bus.mem_addr];
    end

    // Strobes never overlap and done is never more than one-hot
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((bus.mem_read && bus.mem_write) || ($countones(bus.done) > 1)) begin
                errors++;
                $display("FAIL strobe_excl: rd=%b wr=%b done=%b, required no overlap and one-hot done",
                         bus.mem_read, bus.mem_write, bus.done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin model: first pending requester at or after rr_ptr, wrapping
    function automatic int pick(input logic [NR-1:0] pend);
        for (int k = 0; k < int'(NR); k++) begin
            int i;
            i = (rr_ptr + k) % int'(NR);
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]              = w;
        bus.addr[i*AW +: AW]   = a;
        bus.wdata[i*DW +: DW]  = d;
        bus.req[i]             = 1'b1;
    endtask

    task automatic clr_req(input int i);
        bus.req[i] = 1'b0;
    endtask

    // Observe one transaction from an IDLE cycle until its done pulse (bounded)
    task automatic txn_step(output logic [NR-1:0] dv, output logic [DW-1:0] rd,
                            output int nw, output int nr, output logic [AW-1:0] sa,
                            output logic [DW-1:0] sd, output int lat, output int nb);
        dv = '0; rd = '0; nw = 0; nr = 0; sa = '0; sd = '0; lat = 0; nb = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.mem_write) begin nw++; sa = bus.mem_addr; sd = bus.mem_data_in; end
            if (bus.mem_read)  begin nr++; sa = bus.mem_addr; end
            if (bus.done != '0) begin dv = bus.done; rd = bus.rdata; lat = c; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 2'b11; bus.we = 2'b11; bus.addr = '1; bus.wdata = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.done, bus.rdata, bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_data_in} !== '0)
                begin errors++; $display("FAIL reset_outputs: done=%b rdata=%h busy=%b rd=%b wr=%b addr=%h din=%h, required all 0",
                      bus.done, bus.rdata, bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_data_in); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.req = '0; rr_ptr = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.done !== '0)
            begin errors++; $display("FAIL idle_quiet: busy=%b rd=%b wr=%b done=%b, required 0", bus.busy, bus.mem_read, bus.mem_write, bus.done); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        set_req(0, OP_WRITE, 5'd5, 8'hA5);
        txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
        clr_req(0);
        ref_mem[5] = 8'hA5; rr_ptr = 1;
        checks++;
        if (dv !== 2'b01 || lat !== 4) begin errors++; $display("FAIL wr_done: done=%b lat=%0d, required 01 lat=4", dv, lat); end
        checks++;
        if (nw !== 1 || nr !== 0 || sa !== 5'd5 || sd !== 8'hA5)
            begin errors++; $display("FAIL wr_strobe: nw=%0d nr=%0d addr=%0d data=%h, required 1 0 5 a5", nw, nr, sa, sd); end
        checks++;
        if (nb !== 3) begin errors++; $display("FAIL wr_busy: busy cycles=%0d, required 3", nb); end
        set_req(0, OP_READ, 5'd5, 8'h00);
        txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
        clr_req(0);
        checks++;
        if (dv !== 2'b01 || nr !== 1 || nw !== 0 || lat !== 4)
            begin errors++; $display("FAIL rd_done: done=%b nr=%0d nw=%0d lat=%0d, required 01 1 0 4", dv, nr, nw, lat); end
        checks++;
        if (rd !== 8'hA5) begin errors++; $display("FAIL rd_data: rdata=%h, required a5", rd); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        int c0, c1, g;
        logic [AW-1:0] ea; logic [DW-1:0] ed;
        c0 = 0; c1 = 0;
        set_req(0, OP_WRITE, AW'(c0), DW'(c0));
        set_req(1, OP_WRITE, AW'(16 + c1), DW'(8'hF0 + c1));
        while (bus.req != '0) begin
            g  = pick(bus.req);
            ea = (g == 0) ? AW'(c0) : AW'(16 + c1);
            ed = (g == 0) ? DW'(c0) : DW'(8'hF0 + c1);
            txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
            checks++;
            if (dv !== (NR'(1) << g) || nw !== 1 || sa !== ea || sd !== ed)
                begin errors++; $display("FAIL rr_grant: done=%b addr=%0d data=%h, required done=%b addr=%0d data=%h",
                      dv, sa, sd, NR'(1) << g, ea, ed); end
            ref_mem[ea] = ed;
            rr_ptr = (g + 1) % int'(NR);
            if (g == 0) begin c0++; if (c0 < 16) set_req(0, OP_WRITE, AW'(c0), DW'(c0)); else clr_req(0); end
            else begin c1++; if (c1 < 16) set_req(1, OP_WRITE, AW'(16 + c1), DW'(8'hF0 + c1)); else clr_req(1); end
        end
        for (int a = 0; a < 32; a++) begin
            int r;
            r = int'($urandom_range(0, NR - 1));
            set_req(r, OP_READ, AW'(a), DW'($urandom));
            txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
            clr_req(r);
            rr_ptr = (r + 1) % int'(NR);
            checks++;
            if (dv !== (NR'(1) << r) || rd !== ref_mem[a])
                begin errors++; $display("FAIL rr_readback: addr=%0d done=%b rdata=%h, required done=%b rdata=%h",
                      a, dv, rd, NR'(1) << r, ref_mem[a]); end
        end
    endtask

    task automatic test_first_simultaneous();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        int exp_g;
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; rr_ptr = 0;
        set_req(0, OP_READ, 5'd1, 8'h00);
        set_req(1, OP_READ, 5'd17, 8'h00);
        for (int t = 0; t < 3; t++) begin
            exp_g = (t == 1) ? 1 : 0;
            txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
            checks++;
            if (dv !== (NR'(1) << exp_g) || rd !== ref_mem[(exp_g == 0) ? 1 : 17])
                begin errors++; $display("FAIL simul_grant%0d: done=%b rdata=%h, required done=%b rdata=%h",
                      t, dv, rd, NR'(1) << exp_g, ref_mem[(exp_g == 0) ? 1 : 17]); end
            rr_ptr = (exp_g + 1) % int'(NR);
        end
        bus.req = '0;
    endtask

    task automatic test_sweep();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        logic [DW-1:0] val;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 32; a++) begin
                val = (p < 2) ? 8'h00 : DW'(a);
                set_req(1, (p % 2 == 0) ? OP_WRITE : OP_READ, AW'(a), val);
                txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
                clr_req(1);
                rr_ptr = 0;
                if (p % 2 == 0) ref_mem[a] = val;
                checks++;
                if (dv !== 2'b10 || sa !== AW'(a) || (p % 2 == 1 && rd !== val))
                    begin errors++; $display("FAIL sweep_p%0d: addr=%0d done=%b maddr=%0d rdata=%h, required done=10 rdata=%h",
                          p, a, dv, sa, rd, val); end
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        logic [NR-1:0] pend; logic op_w [NR]; logic [AW-1:0] op_a [NR]; logic [DW-1:0] op_d [NR];
        int g;
        pend = '0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1 || pend == '0)) begin
                    op_w[i] = 1'($urandom); op_a[i] = AW'($urandom); op_d[i] = DW'($urandom);
                    set_req(i, op_w[i], op_a[i], op_d[i]);
                    pend[i] = 1'b1;
                end
            end
            g = pick(pend);
            txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
            checks++;
            if (dv !== (NR'(1) << g) || lat !== 4 || nb !== 3 || sa !== op_a[g])
                begin errors++; $display("FAIL rand_txn%0d: done=%b lat=%0d busy=%0d addr=%0d, required done=%b lat=4 busy=3 addr=%0d",
                      k, dv, lat, nb, sa, NR'(1) << g, op_a[g]); end
            checks++;
            if (op_w[g]) begin
                if (nw !== 1 || nr !== 0 || sd !== op_d[g])
                    begin errors++; $display("FAIL rand_wr%0d: nw=%0d nr=%0d data=%h, required 1 0 %h", k, nw, nr, sd, op_d[g]); end
                ref_mem[op_a[g]] = op_d[g];
            end else if (nr !== 1 || nw !== 0 || rd !== ref_mem[op_a[g]])
                begin errors++; $display("FAIL rand_rd%0d: nr=%0d nw=%0d rdata=%h, required 1 0 %h", k, nr, nw, rd, ref_mem[op_a[g]]); end
            pend[g] = 1'b0; clr_req(g);
            rr_ptr = (g + 1) % int'(NR);
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] dv; logic [DW-1:0] rd, sd; logic [AW-1:0] sa; int nw, nr, lat, nb;
        logic seen;
        set_req(0, OP_WRITE, 5'd3, 8'h11);
        txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
        clr_req(0); ref_mem[3] = 8'h11; rr_ptr = 1;
        set_req(0, OP_WRITE, 5'd3, 8'h3C);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin @(negedge clk); seen = bus.mem_write; end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_strobe: write strobe seen=%b, required 1", seen); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; clr_req(0);
        ref_mem[3] = 8'h3C; rr_ptr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== '0 || bus.busy !== 1'b0 || bus.mem_write !== 1'b0)
                begin errors++; $display("FAIL mid_abandon%0d: done=%b busy=%b wr=%b, required 0 0 0", c, bus.done, bus.busy, bus.mem_write); end
        end
        @(posedge clk); #1;
        set_req(0, OP_READ, 5'd3, 8'h00);
        set_req(1, OP_READ, 5'd7, 8'h00);
        txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
        clr_req(0);
        checks++;
        if (dv !== 2'b01 || rd !== 8'h3C)
            begin errors++; $display("FAIL mid_readback: done=%b rdata=%h, required 01 3c", dv, rd); end
        txn_step(dv, rd, nw, nr, sa, sd, lat, nb);
        clr_req(1);
        checks++;
        if (dv !== 2'b10 || rd !== ref_mem[7])
            begin errors++; $display("FAIL mid_second: done=%b rdata=%h, required 10 %h", dv, rd, ref_mem[7]); end
    endtask

    initial begin
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_first_simultaneous();
        test_sweep();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
